// File: rtl/prog_udp_engine.sv
// Runtime-programmable N-input truth-table engine with registered output.
// Optional sequential mode folds out_q back in as the table MSB for UDP-style state.
module prog_udp_engine #(
  parameter int unsigned  N_IN = 3,
  parameter logic [127:0] INIT = 128'hD5D5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [N_IN-1:0] in_data,
  output logic            in_ready,
  input  logic            seq_mode,
  output logic            out_valid,
  output logic            out_q,
  input  logic            cfg_start,
  input  logic            cfg_valid,
  input  logic            cfg_bit,
  output logic            cfg_busy,
  output logic            cfg_done
);

  localparam int unsigned TBL_W = 2 ** (N_IN + 1);
  localparam int unsigned IDX_W = N_IN + 1;
  localparam int unsigned CNT_W = N_IN + 2;

  typedef enum logic [0:0] {StIdle, StLoad} state_e;

  state_e             state_q, state_d;
  logic [TBL_W-1:0]   table_q, table_d;
  logic [TBL_W-1:0]   shadow_q, shadow_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               out_d;
  logic               out_valid_q, out_valid_d;
  logic               cfg_done_q, cfg_done_d;

  logic               accept;
  logic               start;
  logic               beat;
  logic               last_beat;
  logic [IDX_W-1:0]   eval_idx;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (cfg_start) state_d = StLoad;
      StLoad:  if (last_beat) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Unregistered outputs decode the state directly
  always_comb begin
    in_ready = 1'b0;
    cfg_busy = 1'b0;
    unique case (state_q)
      StIdle:  in_ready = 1'b1;
      StLoad:  cfg_busy = 1'b1;
      default: in_ready = 1'b0;
    endcase
  end

  assign accept    = in_valid & in_ready;
  assign start     = cfg_start & in_ready;
  assign beat      = cfg_valid & cfg_busy;
  assign last_beat = beat && (cnt_q == CNT_W'(TBL_W - 1));
  assign eval_idx  = {seq_mode & out_q, in_data};

  // Datapath next-state; the committed table includes the final beat's bit
  always_comb begin
    shadow_d    = shadow_q;
    cnt_d       = cnt_q;
    table_d     = table_q;
    out_d       = out_q;
    out_valid_d = accept;
    cfg_done_d  = last_beat;

    if (start) begin
      shadow_d = '0;
      cnt_d    = '0;
    end else if (beat) begin
      shadow_d[cnt_q[IDX_W-1:0]] = cfg_bit;
      cnt_d                      = cnt_q + CNT_W'(1);
    end

    if (last_beat) begin
      table_d = shadow_d;
    end

    if (accept) begin
      out_d = table_q[eval_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      table_q     <= INIT[TBL_W-1:0];
      shadow_q    <= '0;
      cnt_q       <= '0;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
      cfg_done_q  <= 1'b0;
    end else begin
      table_q     <= table_d;
      shadow_q    <= shadow_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      cfg_done_q  <= cfg_done_d;
    end
  end

  assign out_valid = out_valid_q;
  assign cfg_done  = cfg_done_q;

endmodule

// File: tb/tb_prog_udp_engine.sv
// Scoreboard bench for prog_udp_engine: a truth-table model predicts each accepted
// evaluation; a monitor pops predictions whenever out_valid is seen.
module tb_prog_udp_engine;

  localparam int TW = 16;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [2:0] in_data;
  logic       in_ready;
  logic       seq_mode;
  logic       out_valid;
  logic       out_q;
  logic       cfg_start;
  logic       cfg_valid;
  logic       cfg_bit;
  logic       cfg_busy;
  logic       cfg_done;

  prog_udp_engine #(.N_IN(3), .INIT(128'hD5D5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .seq_mode  (seq_mode),
    .out_valid (out_valid),
    .out_q     (out_q),
    .cfg_start (cfg_start),
    .cfg_valid (cfg_valid),
    .cfg_bit   (cfg_bit),
    .cfg_busy  (cfg_busy),
    .cfg_done  (cfg_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit v;
    int cyc;
  } exp_t;

  exp_t      sbq[$];
  int        cyc = 0;
  int        n_cmp = 0;
  int        n_err = 0;
  int        done_cnt = 0;
  int        exp_done = 0;

  // Reference model: the active table, the state bit, and whether evaluations are accepted
  bit [TW-1:0] m_tbl;
  bit          m_q;
  bit          m_idle;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input int act, input int exp);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: one prediction per out_valid pulse, due exactly one cycle after acceptance
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (out_valid) begin
        if (sbq.size() == 0) begin
          fail_now("unexpected_out_valid", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("out_q", int'(out_q), int'(e.v));
          chk("out_latency_cycle", cyc, e.cyc);
        end
      end else if (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
        e = sbq.pop_front();
        fail_now("missing_out_valid", 0, 1);
      end
      if (cfg_done) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_tbl  = 16'hD5D5;
    m_q    = 1'b0;
    m_idle = 1'b1;
  endtask

  // Predict an evaluation accepted at the coming edge
  task automatic push_eval(input bit [2:0] d, input bit s);
    bit [3:0] idx;
    exp_t     e;
    idx   = {s ? m_q : 1'b0, d};
    e.v   = m_tbl[idx];
    e.cyc = cyc + 1;
    m_q   = e.v;
    sbq.push_back(e);
  endtask

  task automatic eval(input bit [2:0] d, input bit s);
    in_valid = 1'b1;
    in_data  = d;
    seq_mode = s;
    if (m_idle) push_eval(d, s);
    tick();
    in_valid = 1'b0;
  endtask

  // Serial load of val; stops after nbeats (no commit if short). noisy adds gaps,
  // blocked evaluation attempts and stray cfg_start pulses during the load.
  task automatic load(input bit [15:0] val, input int nbeats, input bit with_eval,
                      input bit noisy);
    int d0;
    d0        = done_cnt;
    cfg_start = 1'b1;
    cfg_valid = 1'b1;
    cfg_bit   = ~val[0];
    if (with_eval) begin
      in_valid = 1'b1;
      in_data  = 3'($urandom);
      seq_mode = 1'($urandom);
      push_eval(in_data, seq_mode);
    end
    tick();
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    in_valid  = 1'b0;
    m_idle    = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      if (noisy) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid  = 1'b1;
          in_data   = 3'($urandom);
          cfg_start = 1'($urandom);
          chk("load_in_ready", int'(in_ready), 0);
          tick();
        end
        in_valid  = 1'b0;
        cfg_start = 1'b0;
      end
      if (i == TW - 1) chk("done_before_last_beat", done_cnt, d0);
      chk("load_cfg_busy", int'(cfg_busy), 1);
      cfg_valid = 1'b1;
      cfg_bit   = val[i];
      cfg_start = noisy ? 1'($urandom) : 1'b0;
      tick();
      cfg_valid = 1'b0;
      cfg_start = 1'b0;
    end
    if (nbeats == TW) begin
      m_tbl  = val;
      m_idle = 1'b1;
      exp_done++;
      chk("cfg_done_pulse", int'(cfg_done), 1);
      chk("done_cycle_in_ready", int'(in_ready), 1);
      chk("done_cycle_cfg_busy", int'(cfg_busy), 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    seq_mode  = 1'b0;
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    cfg_bit   = 1'b0;
    model_reset();
    #12;
    chk("rst_out_q", int'(out_q), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_cfg_done", int'(cfg_done), 0);
    chk("rst_cfg_busy", int'(cfg_busy), 0);
    #10 rst_n = 1'b1;
    tick();
    chk("idle_in_ready", int'(in_ready), 1);

    // Reset table, combinational sweep back-to-back
    for (int k = 0; k < 8; k++) eval(3'(k), 1'b0);
    tick();

    // Load 55AA with eval+start+valid in one cycle, then T-toggle and hold
    load(16'h55AA, TW, 1'b1, 1'b0);
    repeat (4) eval(3'b001, 1'b1);
    repeat (2) eval(3'b000, 1'b1);
    tick();

    // Atomic commit: half of an all-zero load, blocked evaluation, then completion
    load(16'h0000, TW / 2, 1'b0, 1'b1);
    in_valid = 1'b1;
    in_data  = 3'b000;
    seq_mode = 1'b0;
    chk("midload_in_ready", int'(in_ready), 0);
    tick();
    tick();
    in_valid = 1'b0;
    for (int i = TW / 2; i < TW; i++) begin
      cfg_valid = 1'b1;
      cfg_bit   = 1'b0;
      tick();
    end
    cfg_valid = 1'b0;
    m_tbl     = 16'h0000;
    m_idle    = 1'b1;
    exp_done++;
    chk("atomic_cfg_done", int'(cfg_done), 1);
    eval(3'b000, 1'b0);
    tick();

    // Asynchronous reset mid-load
    load(16'hFFFF, 7, 1'b0, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_cfg_busy", int'(cfg_busy), 0);
    chk("async_rst_out_q", int'(out_q), 0);
    chk("async_rst_out_valid", int'(out_valid), 0);
    chk("async_rst_cfg_done", int'(cfg_done), 0);
    #2 rst_n = 1'b1;
    model_reset();
    tick();
    chk("post_rst_in_ready", int'(in_ready), 1);
    eval(3'b001, 1'b0);
    eval(3'b111, 1'b0);
    tick();

    // Randomized loads and mixed evaluations
    for (int r = 0; r < 12; r++) begin
      load(16'($urandom), TW, 1'($urandom), 1'b1);
      for (int k = 0; k < 8; k++) eval(3'(k), 1'b0);
      repeat (10) begin
        eval(3'($urandom), 1'($urandom));
        if ($urandom_range(0, 3) == 0) tick();
      end
    end

    repeat (3) tick();
    chk("scoreboard_drained", sbq.size(), 0);
    chk("cfg_done_total", done_cnt, exp_done);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/prog_udp_engine.md
# prog_udp_engine

Parametrised, clocked successor to the team's fixed truth-table primitives. Evaluates an N-input Boolean function held in a runtime-loadable truth table and registers the result. An optional sequential mode feeds the registered output back as an extra table index bit, which gives UDP-style state behaviour. Sits between stimulus/control logic and downstream consumers that need a reprogrammable decode or state function without re-synthesis.

## Interface
- `N_IN`, default 3: number of function inputs, range 1–6.
- `TBL_W`, default 2^(N_IN+1), derived, not overridable: truth-table width in bits.
- `INIT`, default 16'hD5D5: reset truth table.
  - Bit i is the output for index i.
  - The low half 8'hD5 equals minterms {0,2,4,6,7}.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: evaluation request.
- `in_data` in N_IN: function inputs. The MSB is input A.
- `in_ready` out 1: engine accepts an evaluation.
- `seq_mode` in 1: 0 selects combinational table, 1 selects sequential table. Sampled with each accepted request.
- `out_valid` out 1: one-cycle pulse, `out_q` is updated.
- `out_q` out 1: registered function output, which is also the state bit.
- `cfg_start` in 1: begin a table load.
- `cfg_valid` in 1: `cfg_bit` is valid this cycle.
- `cfg_bit` in 1: serial table bit, index 0 first.
- `cfg_busy` out 1: load in progress.
- `cfg_done` out 1: one-cycle pulse, new table committed.

## Operation
- Storage:
  - `table_q` is the active table, TBL_W bits.
  - `shadow_q` is the load buffer, TBL_W bits.
  - `cnt_q` is the load counter, N_IN+2 bits.
  - FSM states are IDLE and LOAD.
- IDLE:
  - `in_ready`=1 and `cfg_busy`=0.
  - A request is accepted when `in_valid`&`in_ready`.
  - The index is {1'b0,`in_data`} when `seq_mode`=0, and {`out_q`,`in_data`} when `seq_mode`=1.
  - On accept, `out_q` <= `table_q`[index] and `out_valid` <= 1 on the next edge.
- `cfg_start` in IDLE:
  - Moves to LOAD, with `cnt_q`=0 and `shadow_q` cleared to 0.
  - An evaluation presented in the same cycle is accepted; evaluation wins for that cycle.
  - Any `cfg_valid` in that cycle is ignored.
- LOAD:
  - `in_ready`=0 and `cfg_busy`=1.
  - Each `cfg_valid` writes `shadow_q`[`cnt_q`] <= `cfg_bit` and increments `cnt_q`.
  - `cfg_start` in LOAD is ignored; no restart.
- Load completion:
  - The write with `cnt_q`=TBL_W−1 is the last one.
  - On that edge, `table_q` <= the completed shadow, including the final bit.
  - The FSM returns to IDLE and `cfg_done` pulses high for 1 cycle.
- Commit is atomic. `table_q` never holds a partial load, so there is no mixed-table evaluation.
- `out_q` holds its value between evaluations and through loads.
- Reset, asynchronous, at any time including mid-load:
  - `table_q`=INIT, `shadow_q`=0, `cnt_q`=0, state IDLE.
  - `out_q`=0, `out_valid`=0, `cfg_done`=0, `cfg_busy`=0.
  - `in_ready` becomes 1 on deassertion.

## Timing
- Evaluation latency is 1 cycle from the accepting edge to `out_q`/`out_valid`.
- Throughput is 1 evaluation per cycle in IDLE. Back-to-back sequential evaluations use the just-updated `out_q`.
- Load length is exactly TBL_W `cfg_valid` beats. Gaps between beats are allowed and have unbounded length.
- `cfg_done` is asserted the cycle after the final beat's edge. `in_ready` is 1 in that same cycle.
- Table selection for evaluation:
  - The first evaluation accepted in the `cfg_done` cycle uses the new table.
  - Evaluations accepted before `cfg_start` use the old table.
- `in_valid` while `in_ready`=0 is not accepted and is not queued. The requester must hold it.
- All outputs are registered except `in_ready` and `cfg_busy`, which decode the FSM state directly.

## Test plan
- Reset table in combinational mode.
  - Stimulus: reset, then `seq_mode`=0 with `in_data` swept 0..7, one per cycle.
  - Required: `out_q` sequence 1,0,1,0,1,0,1,1, each result one cycle after its accept, with `out_valid` high every cycle.
- Load and sequential T-toggle.
  - Stimulus: `cfg_start`, then 16 beats of 16'h55AA, LSB first.
  - Required: `cfg_done` pulses once.
  - Stimulus: `seq_mode`=1 with `in_data`=3'b001 for 4 cycles.
  - Required: `out_q` toggles 1,0,1,0.
  - Stimulus: `in_data`=3'b000.
  - Required: `out_q` holds.
- Atomic commit.
  - Stimulus: mid-load (8 beats of 16'h0000 sent).
  - Required: `in_ready`=0 and `in_valid` is ignored.
  - Stimulus: after completion, evaluate `in_data`=3'b000 with `seq_mode`=0.
  - Required: `out_q`=0.
- Reset mid-load.
  - Stimulus: after 7 beats, pulse `rst_n` low asynchronously, not at a clock edge.
  - Required: outputs clear immediately, `cfg_busy`=0.
  - Stimulus: evaluate 3'b001, then 3'b111.
  - Required: `out_q`=0, then 1 (INIT restored).
- Simultaneous events.
  - Stimulus: `cfg_start`+`in_valid`+`cfg_valid` in the same IDLE cycle.
  - Required: the evaluation completes.
  - Required: the load needs a full 16 subsequent beats.
  - Required: `cfg_start` during LOAD does not reset `cnt_q`.
